fp4_mul_sched: RTL

FP4_MUL_SCHED -- requirements
Module: fp4_mul_sched

---
 rtl/fp4_mul_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fp4_mul_sched.sv
// Round-robin scheduler sharing one pipelined FP4 multiplier between NUM_REQ requesters.
// Optional issue/stall statistics counters are built when FP4_MUL_SCHED_STATS_EN is defined.
module fp4_mul_sched #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [4*NUM_REQ-1:0] i_req_a,
  input  logic [4*NUM_REQ-1:0] i_req_b,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_mul_valid,
  output logic [3:0]           o_mul_a,
  output logic [3:0]           o_mul_b,
  input  logic                 i_mul_valid,
  input  logic [3:0]           i_mul_result,
  output logic [NUM_REQ-1:0]   o_rsp_valid,
  output logic [3:0]           o_rsp_result,
  output logic                 o_idle,
  output logic                 o_err
`ifdef FP4_MUL_SCHED_STATS_EN
  ,
  output logic [15:0]          o_issue_cnt,
  output logic [15:0]          o_stall_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = IDX_W + 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_found;
  logic [CW-1:0]    cand;
  logic             xfer;

  logic [IDX_W-1:0] idx_p0;
  logic [MUL_LAT-1:0] tag_vld_p1;
  logic [IDX_W-1:0] tag_idx_p1 [MUL_LAT];

  logic             tail_vld;
  logic [IDX_W-1:0] tail_idx;

  // Arbitration: first valid requester at or after ptr, wrapping around
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!gnt_found && i_req_valid[cand[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Grant is suppressed while reset is held so no transfer can be seen during reset
  assign xfer        = i_en && gnt_found && i_rst_n;
  assign o_req_ready = xfer ? (ONE_HOT0 << gnt_idx) : '0;

  assign tail_vld = tag_vld_p1[MUL_LAT-1];
  assign tail_idx = tag_idx_p1[MUL_LAT-1];
  assign o_idle   = !o_mul_valid && (tag_vld_p1 == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Issue stage: operands and owner index registered towards the multiplier
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mul_valid <= 1'b0;
      o_mul_a     <= '0;
      o_mul_b     <= '0;
      idx_p0      <= '0;
    end else begin
      o_mul_valid <= xfer;
      if (xfer) begin
        o_mul_a <= i_req_a[{gnt_idx, 2'b00} +: 4];
        o_mul_b <= i_req_b[{gnt_idx, 2'b00} +: 4];
        idx_p0  <= gnt_idx;
      end
    end
  end

  // Tag stages: tail lines up with the multiplier's result strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_vld_p1 <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_idx_p1[s] <= '0;
    end else begin
      tag_vld_p1[0] <= o_mul_valid;
      tag_idx_p1[0] <= idx_p0;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_vld_p1[s] <= tag_vld_p1[s-1];
        tag_idx_p1[s] <= tag_idx_p1[s-1];
      end
    end
  end

  // Response stage: route result to owner; untagged results are dropped and flagged
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid  <= '0;
      o_rsp_result <= '0;
      o_err        <= 1'b0;
    end else begin
      o_rsp_valid <= '0;
      if (i_mul_valid && tail_vld) begin
        o_rsp_valid  <= ONE_HOT0 << tail_idx;
        o_rsp_result <= i_mul_result;
      end
      if (i_mul_valid != tail_vld) o_err <= 1'b1;
    end
  end

`ifdef FP4_MUL_SCHED_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_issue_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (xfer) o_issue_cnt <= sat_inc16(o_issue_cnt);
      if ((|i_req_valid) && !xfer) o_stall_cnt <= sat_inc16(o_stall_cnt);
    end
  end
`else
  // Statistics counters are not present in this build.
`endif

endmodule
